// File: rtl/la_debounce.sv
// Synchronizing debouncer: SYNCPIPE-deep synchronizer, settle-count qualification, clean level with rise/fall strobes.
// Optional registered inverse output qn is built when LA_DEBOUNCE_QN_EN is defined.
module la_debounce #(
  parameter       PROP     = "DEFAULT",
  parameter int   SYNCPIPE = 2,
  parameter int   CNTW     = 8
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            d,
  input  logic [CNTW-1:0] settle,
  output logic            q,
  output logic            rise,
  output logic            fall,
  output logic            busy
`ifdef LA_DEBOUNCE_QN_EN
  ,
  output logic            qn
`endif
);

  logic [SYNCPIPE-1:0] sync_reg;
  logic                s;

  logic                q_reg, q_next;
  logic                rise_reg, rise_next;
  logic                fall_reg, fall_next;
  logic [CNTW-1:0]     cnt_reg, cnt_next;
  logic                upd;

  // Plain flop chain; the non-default branch is where a vendor sync cell gets dropped in.
  generate
    for (genvar gi = 0; gi < SYNCPIPE; gi++) begin : g_sync
      logic stage_in;
      if (gi == 0) begin : g_first
        assign stage_in = d;
      end else begin : g_next
        assign stage_in = sync_reg[gi-1];
      end

      if (PROP == "DEFAULT") begin : g_std
        always_ff @(posedge clk or negedge nreset) begin
          if (!nreset) sync_reg[gi] <= 1'b0;
          else         sync_reg[gi] <= stage_in;
        end
      end else begin : g_cell
        always_ff @(posedge clk or negedge nreset) begin
          if (!nreset) sync_reg[gi] <= 1'b0;
          else         sync_reg[gi] <= stage_in;
        end
      end
    end
  endgenerate

  assign s = sync_reg[SYNCPIPE-1];

  // Any cycle where s matches q discards progress; >= keeps cnt from passing settle.
  always_comb begin
    upd       = 1'b0;
    cnt_next  = cnt_reg;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (s == q_reg) begin
      cnt_next = '0;
    end else if (cnt_reg >= settle) begin
      upd       = 1'b1;
      cnt_next  = '0;
      rise_next = s;
      fall_next = ~s;
    end else begin
      cnt_next = cnt_reg + CNTW'(1);
    end
    q_next = upd ? s : q_reg;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      q_reg    <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      q_reg    <= q_next;
      rise_reg <= rise_next;
      fall_reg <= fall_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign q    = q_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;
  assign busy = (s != q_reg);

`ifdef LA_DEBOUNCE_QN_EN
  logic qn_reg;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)  qn_reg <= 1'b1;
    else if (upd) qn_reg <= ~s;
  end

  assign qn = qn_reg;
`endif

endmodule
